// File: rtl/jk_pkg.sv
// Shared constants for the JK counter: the 2-bit operation encodings.
package jk_pkg;

    typedef enum logic [1:0] {
        MODE_JK   = 2'b00,
        MODE_UP   = 2'b01,
        MODE_DOWN = 2'b10,
        MODE_HOLD = 2'b11
    } mode_e;

endpackage

// File: rtl/jk_ff.sv
// Single-bit rising-edge JK flip-flop with enable, async active-low reset
// and a per-instance reset value.
module jk_ff (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic j,
    input  logic k,
    input  logic rst_val,
    output logic q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= rst_val;
        end else if (en) begin
            case ({j, k})
                2'b10:   q <= 1'b1;
                2'b01:   q <= 1'b0;
                2'b11:   q <= ~q;
                default: q <= q;
            endcase
        end
    end

endmodule

// File: rtl/jk_counter.sv
// Multi-mode counter built from WIDTH JK flip-flops: JK, count up, count down, hold.
// Define JK_COUNTER_SATURATE_EN to saturate at the count limits instead of wrapping.
module jk_counter
    import jk_pkg::*;
#(
    parameter int unsigned          WIDTH     = 4,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    mode_e            op;
    logic [WIDTH-1:0] up_t;
    logic [WIDTH-1:0] dn_t;
    logic [WIDTH-1:0] j_drv;
    logic [WIDTH-1:0] k_drv;

    assign op = mode_e'(mode);

    // Bit i toggles when every lower bit is 1 (up) or 0 (down); bit 0 always toggles.
    always_comb begin
        logic [WIDTH-1:0] low_mask;
        up_t = '0;
        dn_t = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            low_mask = (WIDTH'(1) << i) - WIDTH'(1);
            up_t[i]  = ((q & low_mask) == low_mask);
            dn_t[i]  = ((q & low_mask) == '0);
        end
    end

    assign tc = ((op == MODE_UP)   && (q == {WIDTH{1'b1}})) ||
                ((op == MODE_DOWN) && (q == '0));

    always_comb begin
        j_drv = '0;
        k_drv = '0;
        case (op)
            MODE_JK: begin
                j_drv = j;
                k_drv = k;
            end
            MODE_UP: begin
                j_drv = up_t;
                k_drv = up_t;
            end
            MODE_DOWN: begin
                j_drv = dn_t;
                k_drv = dn_t;
            end
            default: begin
                j_drv = '0;
                k_drv = '0;
            end
        endcase
`ifdef JK_COUNTER_SATURATE_EN
        // tc is only ever set in a count mode, so this never disturbs JK mode.
        if (tc) begin
            j_drv = '0;
            k_drv = '0;
        end
`endif
    end

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
        jk_ff u_ff (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (en),
            .j       (j_drv[i]),
            .k       (k_drv[i]),
            .rst_val (RESET_VAL[i]),
            .q       (q[i])
        );
    end

`ifdef JK_COUNTER_SATURATE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap <= 1'b0;
        end else begin
            wrap <= 1'b0;
        end
    end
`else
    logic count_step;
    assign count_step = en && ((op == MODE_UP) || (op == MODE_DOWN));

    // One-cycle pulse: cleared after any edge that is not a wrapping step, en=0 included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap <= 1'b0;
        end else begin
            wrap <= count_step && tc;
        end
    end
`endif

endmodule

// File: tb/tb_jk_counter.sv
// Self-checking bench for jk_counter: directed scenarios plus randomized
// stimulus against an arithmetic reference model.
module tb_jk_counter;

    localparam int unsigned      W   = 4;
    localparam logic [W-1:0]     RV2 = 4'b1001;
    localparam logic [W-1:0]     ALL1 = 4'b1111;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic [1:0]   mode;
    logic [W-1:0] j;
    logic [W-1:0] k;
    logic [W-1:0] q;
    logic         tc;
    logic         wrap;
    logic [W-1:0] q2;
    logic         tc2;
    logic         wrap2;

    jk_counter #(.WIDTH(W), .RESET_VAL('0)) dut (
        .clk (clk), .rst_n (rst_n), .en (en), .mode (mode),
        .j (j), .k (k), .q (q), .tc (tc), .wrap (wrap)
    );

    jk_counter #(.WIDTH(W), .RESET_VAL(RV2)) dut_rv (
        .clk (clk), .rst_n (rst_n), .en (en), .mode (mode),
        .j (j), .k (k), .q (q2), .tc (tc2), .wrap (wrap2)
    );

    // clock / reset
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] m_q, m_q2;
    logic         m_wrap, m_wrap2;
    logic [2*W+1:0] exp_q[$];

    // Reference model: returns {wrap, next_q}
    function automatic logic [W:0] ref_next(input logic [W-1:0] cur, input logic e,
                                            input logic [1:0] md,
                                            input logic [W-1:0] jj, input logic [W-1:0] kk);
        logic [W-1:0] nq;
        nq = cur;
        if (!e) return {1'b0, cur};
        case (md)
            2'b00: begin
                for (int i = 0; i < int'(W); i++) begin
                    if (jj[i] && !kk[i]) nq[i] = 1'b1;
                    else if (!jj[i] && kk[i]) nq[i] = 1'b0;
                    else if (jj[i] && kk[i]) nq[i] = ~cur[i];
                end
                return {1'b0, nq};
            end
            2'b01: begin
                if (cur == ALL1) begin
`ifdef JK_COUNTER_SATURATE_EN
                    return {1'b0, cur};
`else
                    return {1'b1, W'(0)};
`endif
                end
                return {1'b0, W'((int'(cur) + 1) % 16)};
            end
            2'b10: begin
                if (cur == '0) begin
`ifdef JK_COUNTER_SATURATE_EN
                    return {1'b0, cur};
`else
                    return {1'b1, ALL1};
`endif
                end
                return {1'b0, W'(int'(cur) - 1)};
            end
            default: return {1'b0, cur};
        endcase
    endfunction

    function automatic logic ref_tc(input logic [W-1:0] cur, input logic [1:0] md);
        return (md == 2'b01 && cur == ALL1) || (md == 2'b10 && cur == '0);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // driver: apply inputs for one edge, then score both instances
    task automatic step(input logic e, input logic [1:0] md,
                        input logic [W-1:0] jj, input logic [W-1:0] kk);
        logic [W:0] n1, n2;
        logic [2*W+1:0] ent;
        en = e; mode = md; j = jj; k = kk;
        n1 = ref_next(m_q, e, md, jj, kk);
        n2 = ref_next(m_q2, e, md, jj, kk);
        exp_q.push_back({n2, n1});
        @(posedge clk);
        #1;
        ent = exp_q.pop_front();
        {m_wrap2, m_q2, m_wrap, m_q} = ent;
        check("q", 32'(q), 32'(m_q));
        check("wrap", 32'(wrap), 32'(m_wrap));
        check("tc", 32'(tc), 32'(ref_tc(m_q, mode)));
        check("q_rv", 32'(q2), 32'(m_q2));
        check("wrap_rv", 32'(wrap2), 32'(m_wrap2));
    endtask

    // assert reset between edges (called at posedge+1), check, release at negedge
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        m_q = '0; m_q2 = RV2; m_wrap = 1'b0; m_wrap2 = 1'b0;
        check("rst_q", 32'(q), 32'(m_q));
        check("rst_wrap", 32'(wrap), 32'(m_wrap));
        check("rst_q_rv", 32'(q2), 32'(m_q2));
        check("rst_tc", 32'(tc), 32'(ref_tc(m_q, mode)));
        check("rst_tc_rv", 32'(tc2), 32'(ref_tc(m_q2, mode)));
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; mode = 2'b00; j = '0; k = '0;
        m_q = '0; m_q2 = RV2; m_wrap = 1'b0; m_wrap2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("init_q", 32'(q), 32'h0);
        check("init_q_rv", 32'(q2), 32'(RV2));
        check("init_wrap", 32'(wrap), 32'h0);
        check("init_tc", 32'(tc), 32'h0);
        #4;
        rst_n = 1'b1;

        // JK set/clear, toggle, hold
        step(1'b1, 2'b00, 4'b1010, 4'b0101);
        check("jk_setclr", 32'(q), 32'b1010);
        step(1'b1, 2'b00, 4'b1111, 4'b1111);
        check("jk_toggle", 32'(q), 32'b0101);
        step(1'b1, 2'b00, 4'b0000, 4'b0000);
        check("jk_hold", 32'(q), 32'b0101);

        // up count through the top
        async_reset();
        for (int n = 0; n < 15; n++) step(1'b1, 2'b01, 4'b1111, 4'b0000);
        check("up_full", 32'(q), 32'b1111);
        check("up_tc", 32'(tc), 32'h1);
        step(1'b1, 2'b01, 4'b0000, 4'b1111);
`ifdef JK_COUNTER_SATURATE_EN
        check("up_sat_q", 32'(q), 32'b1111);
        check("up_sat_wrap", 32'(wrap), 32'h0);
`else
        check("up_wrap_q", 32'(q), 32'b0000);
        check("up_wrap", 32'(wrap), 32'h1);
`endif
        step(1'b1, 2'b11, 4'b0000, 4'b0000);
        check("wrap_pulse_end", 32'(wrap), 32'h0);

        // down count from zero
        async_reset();
        mode = 2'b10;
        #1;
        check("down_tc_before", 32'(tc), 32'h1);
        step(1'b1, 2'b10, 4'b0000, 4'b0000);
`ifndef JK_COUNTER_SATURATE_EN
        check("down_wrap_q", 32'(q), 32'b1111);
        check("down_wrap", 32'(wrap), 32'h1);
        check("down_tc_after", 32'(tc), 32'h0);
`endif

        // enable low holds everything
        step(1'b1, 2'b00, 4'b0110, 4'b1001);
        check("en_setup", 32'(q), 32'b0110);
        for (int n = 0; n < 5; n++) step(1'b0, 2'b01, 4'b1111, 4'b1111);
        check("en_low_q", 32'(q), 32'b0110);
        check("en_low_wrap", 32'(wrap), 32'h0);

        // asynchronous reset mid-state
        step(1'b1, 2'b00, 4'b1011, 4'b0100);
        check("pre_rst_q", 32'(q), 32'b1011);
        async_reset();
        check("async_q", 32'(q), 32'b0000);
        check("async_q_rv", 32'(q2), 32'b1001);

        // mode switching
        for (int n = 0; n < 3; n++) step(1'b1, 2'b01, 4'b0000, 4'b0000);
        check("sw_up", 32'(q), 32'b0011);
        step(1'b1, 2'b10, 4'b1111, 4'b1111);
        check("sw_down", 32'(q), 32'b0010);
        step(1'b1, 2'b11, 4'b1111, 4'b0000);
        check("sw_hold", 32'(q), 32'b0010);

        // randomized
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                 W'($urandom), W'($urandom));
            if ($urandom_range(0, 49) == 0) async_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
